// File: rtl/stalling_memory.sv
// Single-port data memory with a fixed multi-cycle access latency and a
// busy/done/err handshake. Requests are sampled only while idle; the access
// completes LATENCY edges after acceptance.
module stalling_memory #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned LATENCY    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              read_en_i,
   input  logic              write_en_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] write_data_i,
   output logic [DATA_W-1:0] read_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int unsigned BYTE_BITS = $clog2(DATA_W / 8);
   localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   // Mask form avoids a zero-width slice when DATA_W is 8.
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << BYTE_BITS) - 1);
   localparam logic [CNT_W-1:0]  CNT_INIT   = CNT_W'(LATENCY - 1);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   wr_q, wr_d;
   logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic [DATA_W-1:0]      rdata_q, rdata_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic                   mem_we;
   logic                   conflict, misaligned, out_of_range;

   logic [DATA_W-1:0]      mem_q [DEPTH];

   // Request classification against the byte address
   always_comb begin
      conflict     = read_en_i & write_en_i;
      misaligned   = |(addr_i & ALIGN_MASK);
      out_of_range = |(addr_i >> (BYTE_BITS + DEPTH_LOG2));
   end

   // State register and latched access; reset abandons any in-flight access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Storage array, deliberately not reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   // Next-state: accept/reject in idle, count down and complete in wait
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      mem_we  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (read_en_i | write_en_i) begin
               if (conflict | misaligned | out_of_range) begin
                  err_d = 1'b1;
               end else begin
                  state_d = StWait;
                  cnt_d   = CNT_INIT;
                  wr_d    = write_en_i;
                  idx_d   = addr_i[BYTE_BITS +: DEPTH_LOG2];
                  wdata_d = write_data_i;
               end
            end
         end
         StWait: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               done_d  = 1'b1;
               state_d = StIdle;
               if (wr_q) begin
                  mem_we = 1'b1;
               end else begin
                  rdata_d = mem_q[idx_q];
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are all straight from registers
   always_comb begin
      busy_o      = (state_q == StWait);
      done_o      = done_q;
      err_o       = err_q;
      read_data_o = rdata_q;
   end

endmodule

// File: tb/tb_stalling_memory.sv
// Bench for stalling_memory: three instances (default, LATENCY=1, 32-bit wide)
// share one stimulus bus selected by sel; a keyed array models the storage.
module tb_stalling_memory;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          sel = 0;
   logic        read_en = 1'b0;
   logic        write_en = 1'b0;
   logic [15:0] addr = '0;
   logic [31:0] wdata = '0;

   logic [15:0] rd0, rd1;
   logic [31:0] rd2;
   logic        busy0, busy1, busy2, done0, done1, done2, err0, err1, err2;
   logic [31:0] rd_obs;
   logic        busy_obs, done_obs, err_obs;

   int          total = 0;
   int          bad = 0;
   logic [31:0] mdl [int];
   logic [31:0] exp_rd [3];
   time         acc_t, prev_acc;

   always #5 clk = ~clk;

   stalling_memory u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .read_en_i(read_en && sel == 0), .write_en_i(write_en && sel == 0),
      .addr_i(addr), .write_data_i(wdata[15:0]),
      .read_data_o(rd0), .busy_o(busy0), .done_o(done0), .err_o(err0)
   );

   stalling_memory #(.LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .read_en_i(read_en && sel == 1), .write_en_i(write_en && sel == 1),
      .addr_i(addr), .write_data_i(wdata[15:0]),
      .read_data_o(rd1), .busy_o(busy1), .done_o(done1), .err_o(err1)
   );

   stalling_memory #(.DATA_W(32), .DEPTH_LOG2(6)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .read_en_i(read_en && sel == 2), .write_en_i(write_en && sel == 2),
      .addr_i(addr), .write_data_i(wdata),
      .read_data_o(rd2), .busy_o(busy2), .done_o(done2), .err_o(err2)
   );

   always_comb begin
      rd_obs = {16'h0, rd0}; busy_obs = busy0; done_obs = done0; err_obs = err0;
      if (sel == 1) begin
         rd_obs = {16'h0, rd1}; busy_obs = busy1; done_obs = done1; err_obs = err1;
      end else if (sel == 2) begin
         rd_obs = rd2; busy_obs = busy2; done_obs = done2; err_obs = err2;
      end
   end

   function automatic int lat_of(input int s);
      return (s == 1) ? 1 : 4;
   endfunction

   function automatic int bytes_of(input int s);
      return (s == 2) ? 4 : 2;
   endfunction

   function automatic int depth_of(input int s);
      return (s == 2) ? 64 : 1024;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One request on instance s; checks the whole handshake up to completion.
   task automatic do_op(input int s, input bit r, input bit w, input logic [15:0] a,
                        input logic [31:0] d, input bit tog, input bit b2b, input string tag);
      bit ok;
      int n;
      int key;
      int bytes = bytes_of(s);
      logic [31:0] dmask = (s == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      ok  = (r != w) && (int'(a) % bytes == 0) && (int'(a) / bytes < depth_of(s));
      key = s * 65536 + int'(a) / bytes;
      sel = s; read_en = r; write_en = w; addr = a; wdata = d;
      @(posedge clk);
      acc_t = $time;
      #1;
      read_en = 1'b0; write_en = 1'b0;
      if (!ok) begin
         chk({tag, "_err"}, 32'(err_obs), 32'd1);
         chk({tag, "_rbusy"}, 32'(busy_obs), 32'd0);
         chk({tag, "_rdone"}, 32'(done_obs), 32'd0);
         chk({tag, "_rdhold"}, rd_obs, exp_rd[s]);
         @(posedge clk); #1;
         chk({tag, "_errpulse"}, 32'(err_obs), 32'd0);
         chk({tag, "_rbusy2"}, 32'(busy_obs), 32'd0);
      end else begin
         if (b2b) chk({tag, "_cycles"}, 32'((acc_t - prev_acc) / 10), 32'(lat_of(s) + 1));
         prev_acc = acc_t;
         n = 0;
         while (done_obs !== 1'b1 && n < 20) begin
            chk({tag, "_busy"}, 32'(busy_obs), 32'd1);
            chk({tag, "_noerr"}, 32'(err_obs), 32'd0);
            if (tog) begin
               write_en = n[0]; addr = a; wdata = 32'hFFFF;
            end
            @(posedge clk); #1;
            n++;
         end
         write_en = 1'b0;
         chk({tag, "_lat"}, 32'(n), 32'(lat_of(s)));
         chk({tag, "_done"}, 32'(done_obs), 32'd1);
         chk({tag, "_dbusy"}, 32'(busy_obs), 32'd0);
         if (w) mdl[key] = d & dmask;
         else if (mdl.exists(key)) exp_rd[s] = mdl[key];
         chk({tag, "_rdata"}, rd_obs, exp_rd[s]);
      end
   endtask

   task automatic idle_chk(input string tag);
      @(posedge clk); #1;
      chk({tag, "_idone"}, 32'(done_obs), 32'd0);
      chk({tag, "_ibusy"}, 32'(busy_obs), 32'd0);
      chk({tag, "_ierr"}, 32'(err_obs), 32'd0);
      chk({tag, "_ird"}, rd_obs, exp_rd[sel]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int kind;
      logic [15:0] ra;
      logic [31:0] rdv;
      for (int i = 0; i < 3; i++) exp_rd[i] = '0;
      prev_acc = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd", rd_obs, 32'h0);
      chk("rst_busy", 32'(busy_obs), 32'd0);
      chk("rst_done", 32'(done_obs), 32'd0);
      chk("rst_err", 32'(err_obs), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Known data, then abandon a write by reset mid-wait
      do_op(0, 0, 1, 16'h0010, 32'h1111, 0, 0, "w1111");
      do_op(0, 1, 0, 16'h0010, 32'h0, 0, 0, "r1111");
      sel = 0; write_en = 1'b1; addr = 16'h0010; wdata = 32'hBEEF;
      @(posedge clk); #1;
      write_en = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy_obs), 32'd0);
      chk("arst_done", 32'(done_obs), 32'd0);
      chk("arst_err", 32'(err_obs), 32'd0);
      chk("arst_rd", rd_obs, 32'h0);
      for (int i = 0; i < 3; i++) exp_rd[i] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(0, 1, 0, 16'h0010, 32'h0, 0, 0, "rpost");

      // Basic access and hold through a following write
      do_op(0, 0, 1, 16'h0020, 32'hA5C3, 0, 0, "wa5c3");
      idle_chk("after_w");
      do_op(0, 1, 0, 16'h0020, 32'h0, 0, 0, "ra5c3");
      idle_chk("after_r");
      do_op(0, 0, 1, 16'h0022, 32'h5A5A, 0, 0, "w0022");

      // Rejections
      do_op(0, 1, 0, 16'h0021, 32'h0, 0, 0, "misal");
      do_op(0, 1, 0, 16'h0800, 32'h0, 0, 0, "oor");
      do_op(0, 1, 1, 16'h0000, 32'hDEAD, 0, 0, "both");
      do_op(0, 1, 0, 16'h0020, 32'h0, 0, 0, "ra5c3b");

      // Requests while busy are ignored
      do_op(0, 0, 1, 16'h0030, 32'h1234, 0, 0, "w1234");
      do_op(0, 1, 0, 16'h0030, 32'h0, 1, 0, "rtog");
      do_op(0, 1, 0, 16'h0030, 32'h0, 0, 0, "r1234");

      // Back-to-back at LATENCY=4 and LATENCY=1
      do_op(0, 0, 1, 16'h0040, 32'h0F0F, 0, 0, "bb0a");
      do_op(0, 1, 0, 16'h0040, 32'h0, 0, 1, "bb0b");
      do_op(0, 0, 1, 16'h0042, 32'h7777, 0, 1, "bb0c");
      idle_chk("s1_idle");
      do_op(1, 0, 1, 16'h0040, 32'hC0DE, 0, 0, "bb1a");
      do_op(1, 1, 0, 16'h0040, 32'h0, 0, 1, "bb1b");
      do_op(1, 0, 1, 16'h0044, 32'h4444, 0, 1, "bb1c");
      do_op(1, 1, 0, 16'h0044, 32'h0, 0, 1, "bb1d");

      // Wide variant
      do_op(2, 0, 1, 16'h00FC, 32'hDEADBEEF, 0, 0, "wwide");
      do_op(2, 1, 0, 16'h00FC, 32'h0, 0, 0, "rwide");
      do_op(2, 1, 0, 16'h00FE, 32'h0, 0, 0, "wmisal");
      do_op(2, 1, 0, 16'h0100, 32'h0, 0, 0, "woor");

      // Random traffic on the default instance
      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 8));
         ra   = 16'h0100 + 16'($urandom_range(0, 15) * 2);
         rdv  = $urandom;
         if (kind <= 3 || (kind <= 5 && !mdl.exists(int'(ra) / 2)))
            do_op(0, 0, 1, ra, rdv, kind[0], 0, "rnd_w");
         else if (kind <= 5)
            do_op(0, 1, 0, ra, 32'h0, kind[0], 0, "rnd_r");
         else if (kind == 6)
            do_op(0, 1, 0, ra | 16'h0001, 32'h0, 0, 0, "rnd_mis");
         else if (kind == 7)
            do_op(0, 0, 1, ra | 16'h0800, rdv, 0, 0, "rnd_oor");
         else
            do_op(0, 1, 1, ra, rdv, 0, 0, "rnd_both");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stalling_memory.md
# stalling_memory

Parametrised single-port data memory with a configurable multi-cycle access latency and a busy/done handshake. It is the next-generation replacement for the fixed single-cycle data memory wrapper. It gives the pipelined core a realistic stalling memory: width, depth and latency are parameters, and misaligned, out-of-range or conflicting requests raise `err`. The block owns its storage array and sits between the MEM stage and the stall/hazard logic.

## Interface
- `DATA_W`, default 16: word width in bits; must be a power of two and ≥ 8.
- `ADDR_W`, default 16: byte-address width.
- `DEPTH_LOG2`, default 10: log2 of the word count. Require `DEPTH_LOG2 + BYTE_BITS ≤ ADDR_W`.
- `LATENCY`, default 4: cycles from request acceptance to `done`; must be ≥ 1.
- Derived: `BYTE_BITS = log2(DATA_W/8)`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `read_en`  in  1  read request; sampled only in IDLE.
- `write_en`  in  1  write request; sampled only in IDLE.
- `addr`  in  ADDR_W  byte address.
- `write_data`  in  DATA_W  store data.
- `read_data`  out  DATA_W  registered load data.
- `busy`  out  1  access in flight; upstream must hold its request until this is low.
- `done`  out  1  one-cycle completion pulse for reads and writes.
- `err`  out  1  one-cycle pulse flagging a rejected request.

## Operation
- FSM has two states, IDLE and WAIT. A latency counter is sized `clog2(LATENCY)`, with a minimum of 1 bit.
- IDLE, at each rising edge, checks requests in this order:
  - `read_en & write_en`: reject; `err`=1 next cycle.
  - `addr[BYTE_BITS-1:0] != 0` (misaligned): reject; `err`=1.
  - `addr[ADDR_W-1 : BYTE_BITS+DEPTH_LOG2] != 0` (out of range): reject; `err`=1.
  - Otherwise, accept: latch the op, the word index `addr[BYTE_BITS +: DEPTH_LOG2]` and `write_data`; set cnt = LATENCY-1; go to WAIT.
- On a rejected request the state stays IDLE, memory is untouched and `read_data` keeps its value.
- WAIT, at each edge:
  - If cnt ≠ 0: decrement cnt.
  - If cnt = 0: complete the access. A write stores the latched data; a read loads `mem[index]` into `read_data`. Pulse `done`=1 and go to IDLE.
- `read_en`/`write_en` in WAIT are ignored. They are not queued and do not raise `err`.
- `read_data` changes only on read completion. It holds its value through writes and idle cycles.
- Write-then-read to the same index returns the new data, because accesses are strictly serialised.
- Storage contents are not reset and start as X. Software and benches must write before reading.
- `rst_n` low at any time takes effect asynchronously:
  - State goes to IDLE, cnt=0 and `read_data`=0.
  - `busy`, `done` and `err` go to 0.
  - An in-flight access is abandoned; a pending write does not reach the array.

## Timing
- Reset values: `read_data`=0, `busy`=0, `done`=0, `err`=0.
- Accepted request sampled at edge t0:
  - `busy`=1 from after t0 through edge t0+LATENCY, i.e. exactly LATENCY cycles.
  - After edge t0+LATENCY: `busy`=0, `done`=1 for one cycle, and `read_data` is valid (reads).
- `busy` = (state == WAIT), registered. `done` and `err` are registered one-cycle pulses.
- In the `done` cycle the block is already in IDLE. A new request presented then is accepted at the next edge, so sustained throughput is one access per LATENCY+1 cycles.
- LATENCY=1: `busy` high for one cycle, then `done`.
- Rejected request at edge t0: `err`=1 for the cycle after t0; `busy` stays 0 and `done` stays 0.
- `rst_n` deassertion is synchronised externally. The first request may be sampled at the first rising edge with `rst_n`=1.

## Test plan
- **Reset:** assert `rst_n`=0 mid-WAIT of a write 0xBEEF @0x0010. Required: outputs go to 0 immediately. After release, a read @0x0010 following a known write of 0x1111 returns 0x1111, not 0xBEEF.
- **Basic access** (defaults, LATENCY=4): write 0xA5C3 @0x0020, then read @0x0020.
  - Write: `busy` high for 4 cycles, then `done` pulse.
  - Read: `read_data`=0xA5C3 in its `done` cycle, and it holds through a following write to 0x0022.
- **Error cases:** each must give `err`=1 for one cycle, `busy`=0, and no memory change.
  - Read @0x0021 (misaligned).
  - Read @0x0800 with DEPTH_LOG2=10 (out of range).
  - `read_en`=`write_en`=1 @0x0000.
- **Requests while busy:** toggle `write_en` with 0xFFFF @0x0030 during WAIT of a read @0x0030 that holds 0x1234. Required: ignored, with no `err`; the read returns 0x1234 and a later read @0x0030 still returns 0x1234.
- **Back-to-back:** present a new request in the `done` cycle. Required: accepted on the next edge; 5 cycles per access at LATENCY=4. Re-run at LATENCY=1 and check 2 cycles per access.
- **Wide variant** (DATA_W=32, DEPTH_LOG2=6):
  - Write 0xDEADBEEF @0x00FC, read it back: returns 0xDEADBEEF.
  - Read @0x00FE (misaligned): `err`=1.
  - Read @0x0100 (out of range): `err`=1.
